fpu_req_resp: RTL

Sequential request/response front end for the single-cycle FPU datapath (`fonecycle`). It accepts FPU operations from the issue side over a valid/ready handshake and resolves the dynamic rounding mode. It rejects illegal encodings, drives the combinational FPU for exactly one cycle, and registers the result. It then holds that result until the consumer accepts it. It also keeps the sticky architectural `fflags` accumulator used by the fcsr logic.

---
 rtl/fpu_req_resp.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fpu_req_resp.sv
// fpu_req_resp: valid/ready front end for the single-cycle FPU datapath.
// Accepts one op at a time, resolves the dynamic rounding mode, rejects
// illegal encodings without touching the FPU, holds the registered result
// until the consumer takes it, and keeps the sticky fflags accumulator.
module fpu_req_resp #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    // issue side
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [XLEN-1:0]  req_rs3,
    input  logic [4:0]       req_ftype,
    input  logic [2:0]       req_rm,
    input  logic [1:0]       req_fmt,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [2:0]       frm_in,
    input  logic             flush,
    input  logic             fflags_clr,
    // FPU side
    output logic [XLEN-1:0]  fu_frs1,
    output logic [XLEN-1:0]  fu_frs2,
    output logic [XLEN-1:0]  fu_frs3,
    output logic [4:0]       fu_ftype,
    output logic             fu_fcontrol,
    output logic [2:0]       fu_rm,
    output logic [1:0]       fu_fmt,
    input  logic [XLEN-1:0]  fu_res,
    input  logic [4:0]       fu_flags,
    input  logic             fu_flags_valid,
    // response side
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [XLEN-1:0]  rsp_data,
    output logic [4:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_illegal,
    output logic [4:0]       fflags_acc
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Operation as latched at accept; drives the FPU inputs directly.
    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] rs3;
        logic [4:0]      ftype;
        logic [2:0]      rm;
        logic [1:0]      fmt;
    } op_t;

    state_t state, state_nxt;
    op_t    op_q;

    logic [2:0] rm_res;
    logic       req_illegal;
    logic       accept;
    logic       rsp_hs;
    logic [4:0] rsp_contrib;

    // Rounding mode 3'b111 defers to fcsr.frm; 101/110/111 after resolution
    // are reserved, and only single precision is supported.
    assign rm_res      = (req_rm == 3'b111) ? frm_in : req_rm;
    assign req_illegal = (rm_res == 3'b101) || (rm_res == 3'b110) ||
                         (rm_res == 3'b111) || (req_fmt != 2'b00);

    assign req_ready   = (state == IDLE);
    assign rsp_valid   = (state == RESP);
    assign fu_fcontrol = (state == EXEC);
    assign accept      = req_valid & req_ready;
    assign rsp_hs      = rsp_valid & rsp_ready;
    // Rejected ops never raise exceptions in the architectural flags.
    assign rsp_contrib = rsp_illegal ? 5'b0 : rsp_flags;

    assign fu_frs1  = op_q.rs1;
    assign fu_frs2  = op_q.rs2;
    assign fu_frs3  = op_q.rs3;
    assign fu_ftype = op_q.ftype;
    assign fu_rm    = op_q.rm;
    assign fu_fmt   = op_q.fmt;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state: illegal ops skip EXEC; flush aborts EXEC and an unaccepted
    // RESP, but a response taken in the same cycle as flush still completes.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (req_valid) state_nxt = req_illegal ? RESP : EXEC;
            EXEC: state_nxt = flush ? IDLE : RESP;
            RESP: if (rsp_ready || flush) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand latch at accept; held stable for the FPU and the response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            rsp_tag <= '0;
        end else if (accept) begin
            op_q.rs1   <= req_rs1;
            op_q.rs2   <= req_rs2;
            op_q.rs3   <= req_rs3;
            op_q.ftype <= req_ftype;
            op_q.rm    <= rm_res;
            op_q.fmt   <= req_fmt;
            rsp_tag    <= req_tag;
        end
    end

    // Response payload: zeroed for illegal ops at accept, captured from the
    // FPU on the EXEC->RESP edge for legal ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data    <= '0;
            rsp_flags   <= '0;
            rsp_illegal <= 1'b0;
        end else if (accept) begin
            rsp_illegal <= req_illegal;
            if (req_illegal) begin
                rsp_data  <= '0;
                rsp_flags <= '0;
            end
        end else if ((state == EXEC) && !flush) begin
            rsp_data  <= fu_res;
            rsp_flags <= fu_flags_valid ? fu_flags : 5'b0;
        end
    end

    // Sticky fflags: clear wins over accumulate, but a flag set by the
    // response taken in the clearing cycle survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 fflags_acc <= '0;
        else if (fflags_clr && rsp_hs) fflags_acc <= rsp_contrib;
        else if (fflags_clr)        fflags_acc <= '0;
        else if (rsp_hs)            fflags_acc <= fflags_acc | rsp_contrib;
    end

endmodule
